// File: rtl/hazard_detector.sv
// hazard_detector
//   Load-use stall and forwarding-select generator for a 5-stage pipeline.
//   A shadow copy of the E/M/W destination info is kept locally so the block
//   only needs the D-stage instruction fields as inputs.
//
// Ports
//   Clk, Rst_n      clock, asynchronous active-low reset
//   ValidD          a real instruction is present in D
//   RsD, RtD        source registers of the D instruction
//   WriteRegD       destination register of the D instruction
//   RegWriteD       D instruction writes WriteRegD
//   MemToRegD       D instruction is a Load
//   UsesRtD         1: reads Rs and Rt; 0: only Rs is a forwarded operand
//   FlushD          kill the D instruction (taken branch)
//   Type            registered forwarding code for the E-stage instruction
//   StallF, StallD  hold PC and IF/ID
//   FlushE          bubble into ID/EX
//   StallCount      saturating count of load-use stall cycles

package hazard_detector_pkg;
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regWrite;
        logic       load;
    } shadowEntry_t;

    localparam shadowEntry_t BUBBLE = '{valid: 1'b0, dst: 5'd0, regWrite: 1'b0, load: 1'b0};
endpackage

// Per-operand forwarding select: compares one source register against the
// E (distance 1) and M (distance 2) shadow entries. Distance 1 wins.
module hazard_fwd_sel
    import hazard_detector_pkg::*;
(
    input  logic [4:0]   srcReg,
    input  shadowEntry_t entE,
    input  shadowEntry_t entM,
    output logic [1:0]   sel,
    output logic         isLoad,
    output logic         hitE
);
    logic hitM;

    // Register 0 is hard-wired and never a producer.
    assign hitE = entE.valid && entE.regWrite && (entE.dst != 5'd0) && (entE.dst == srcReg);
    assign hitM = entM.valid && entM.regWrite && (entM.dst != 5'd0) && (entM.dst == srcReg);

    always_comb begin
        sel    = 2'b00;
        isLoad = 1'b0;
        if (hitE) begin
            sel    = 2'b01;
            isLoad = entE.load;
        end else if (hitM) begin
            sel    = 2'b10;
            isLoad = entM.load;
        end
    end
endmodule

module hazard_detector
    import hazard_detector_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        ValidD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  WriteRegD,
    input  logic        RegWriteD,
    input  logic        MemToRegD,
    input  logic        UsesRtD,
    input  logic        FlushD,
    output logic [5:0]  Type,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushE,
    output logic [15:0] StallCount
);
    localparam int NUM_OPS = 2;   // operand 0 = Rs, operand 1 = Rt

    shadowEntry_t shE, shM, shW;

    logic [NUM_OPS-1:0][4:0] srcReg;
    logic [NUM_OPS-1:0][1:0] opSel;
    logic [NUM_OPS-1:0]      opLoad;
    logic [NUM_OPS-1:0]      opHitE;

    logic         stall;
    logic         loadE;
    logic [5:0]   typeNext;
    shadowEntry_t entD;

    assign srcReg[0] = RsD;
    assign srcReg[1] = RtD;

    for (genvar g = 0; g < NUM_OPS; g++) begin : gOp
        hazard_fwd_sel uSel (
            .srcReg (srcReg[g]),
            .entE   (shE),
            .entM   (shM),
            .sel    (opSel[g]),
            .isLoad (opLoad[g]),
            .hitE   (opHitE[g])
        );
    end

    // A load in E cannot forward yet; the consumer waits one cycle. FlushD
    // suppresses the stall because the consumer is being killed anyway.
    // Since a stall always inserts a bubble into E, the same D instruction
    // can never stall twice in a row.
    assign stall = ValidD && !FlushD && shE.valid && shE.load &&
                   (opHitE[0] || (UsesRtD && opHitE[1]));

    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;

    assign loadE = ValidD && !FlushD && !stall;

    always_comb begin
        entD          = BUBBLE;
        entD.valid    = 1'b1;
        entD.dst      = WriteRegD;
        entD.regWrite = RegWriteD;
        entD.load     = MemToRegD;
    end

    always_comb begin
        typeNext = 6'b000000;
        if (loadE) begin
            typeNext[5]   = opLoad[0];
            typeNext[3:2] = opSel[0];
            if (UsesRtD) begin
                typeNext[4]   = opLoad[1];
                typeNext[1:0] = opSel[1];
            end else begin
                typeNext[4]   = 1'b0;
                typeNext[1:0] = 2'b11;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            shE  <= BUBBLE;
            shM  <= BUBBLE;
            shW  <= BUBBLE;
            Type <= 6'b000000;
        end else begin
            shW  <= shM;
            shM  <= shE;
            shE  <= loadE ? entD : BUBBLE;
            Type <= typeNext;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            StallCount <= 16'd0;
        end else if (stall && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end
endmodule
